riscv_exec_mem: RTL and testbench

- Execute/memory slice of the single-cycle RV32I core: instruction decode (control), ALU, branch resolution and data memory, plus write-back select.
- Upstream: PC, IMEM, register file and immediate generator feed it.
- Outputs drive the register-file write port and the next-PC mux.
- Only the data memory holds state; everything else is combinational.

---
 rtl/riscv_pkg.sv | 65 ++++++
 rtl/riscv_dmem.sv | 82 ++++++++
 rtl/riscv_exec_mem.sv | 160 ++++++++++++++++
 tb/tb_riscv_exec_mem.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the execute/memory slice: opcodes, ALU ops,
// next-PC select encodings and funct3 values.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLL   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_SRA   = 4'h7,
    ALU_SLT   = 4'h8,
    ALU_SLTU  = 4'h9,
    ALU_PASSB = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_REL  = 2'b01,
    PC_JALR = 2'b10
  } pc_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // alt selects SUB on funct3=000 and SRA on funct3=101; callers gate it.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem.sv
// Data memory: combinational read, clocked write, asynchronous clear on reset.
// RVX_SUBWORD_EN enables byte/halfword loads and stores via byte enables.
module riscv_dmem
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef RVX_SUBWORD_EN
  input  logic [2:0]  funct3,
`endif
  output logic [31:0] rdata
);

  logic [31:0]        mem [DMEM_WORDS];
  logic [DMEM_AW-1:0] word_idx;
  logic [31:0]        word;
  logic [31:0]        wr_word;
  logic [3:0]         be;

  assign word_idx = addr[DMEM_AW+1:2];
  assign word     = mem[word_idx];

`ifdef RVX_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_addr;

  assign unused_addr = ^addr[31:DMEM_AW+2];
  assign byte_sel    = word[8*addr[1:0] +: 8];
  assign half_sel    = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    be      = '1;
    wr_word = wdata;
    case (funct3)
      F3_SB: begin
        be      = 4'b0001 << addr[1:0];
        wr_word = {4{wdata[7:0]}};
      end
      F3_SH: begin
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = word;
    case (funct3)
      F3_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  rdata = {24'd0, byte_sel};
      F3_LHU:  rdata = {16'd0, half_sel};
      default: rdata = word;
    endcase
  end
`else
  logic unused_addr;

  assign unused_addr = ^{addr[31:DMEM_AW+2], addr[1:0]};
  assign be          = '1;
  assign wr_word     = wdata;
  assign rdata       = word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
    end else if (mem_write) begin
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/riscv_exec_mem.sv
// Single-cycle RV32I execute/memory slice: decode, ALU, branch resolution,
// data memory and write-back select. RVX_SUBWORD_EN enables sub-word accesses.
module riscv_exec_mem
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus_4,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        reg_write,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [1:0]  pc_src,
  output logic [31:0] wb_data
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic        unused_instr;

  logic        mem_write;
  logic        mem_to_reg;
  logic        link;
  logic        is_branch;
  logic        taken;
  alu_op_e     alu_op;
  pc_sel_e     pc_sel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] load_data;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f7b5         = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    is_branch  = 1'b0;
    alu_op     = ALU_ADD;
    pc_sel     = PC_SEQ;
    src_a      = rs1_data;
    src_b      = rs2_data;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = alu_decode(funct3, f7b5);
      end
      OP_IMM: begin
        reg_write = 1'b1;
        src_b     = imm;
        // instr[30] is immediate data except for SRAI
        alu_op    = alu_decode(funct3, f7b5 && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        src_b      = imm;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        src_b     = imm;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        link      = 1'b1;
        pc_sel    = PC_REL;
        src_a     = pc;
        src_b     = imm;
      end
      OP_JALR: begin
        reg_write = 1'b1;
        link      = 1'b1;
        pc_sel    = PC_JALR;
        src_b     = imm;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_op    = ALU_PASSB;
        src_b     = imm;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        src_a     = pc;
        src_b     = imm;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD:   alu_result = src_a + src_b;
      ALU_SUB:   alu_result = src_a - src_b;
      ALU_AND:   alu_result = src_a & src_b;
      ALU_OR:    alu_result = src_a | src_b;
      ALU_XOR:   alu_result = src_a ^ src_b;
      ALU_SLL:   alu_result = src_a << src_b[4:0];
      ALU_SRL:   alu_result = src_a >> src_b[4:0];
      ALU_SRA:   alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
      ALU_SLT:   alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_result = {31'd0, src_a < src_b};
      ALU_PASSB: alu_result = src_b;
      default:   alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data < rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

  assign pc_src = (is_branch && taken) ? PC_REL : pc_sel;

  riscv_dmem #(
    .DMEM_WORDS(DMEM_WORDS),
    .DMEM_AW   (DMEM_AW)
  ) u_dmem (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_write(mem_write),
    .addr     (alu_result),
    .wdata    (rs2_data),
`ifdef RVX_SUBWORD_EN
    .funct3   (funct3),
`endif
    .rdata    (load_data)
  );

  always_comb begin
    if (mem_to_reg)  wb_data = load_data;
    else if (link)   wb_data = pc_plus_4;
    else             wb_data = alu_result;
  end

endmodule

// File: tb/tb_riscv_exec_mem.sv
// Directed self-checking bench for riscv_exec_mem (default and RVX_SUBWORD_EN builds).
module tb_riscv_exec_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc, pc_plus_4, rs1_data, rs2_data, imm;
  logic        reg_write, zero;
  logic [31:0] alu_result, wb_data;
  logic [1:0]  pc_src;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_exec_mem #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .pc        (pc),
    .pc_plus_4 (pc_plus_4),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .reg_write (reg_write),
    .alu_result(alu_result),
    .zero      (zero),
    .pc_src    (pc_src),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 10'd0, f3, 5'd1, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction just after a falling edge and let it settle.
  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    @(negedge clk);
    instr = i; rs1_data = a; rs2_data = b; imm = im;
    #1;
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011;

  initial begin
    rst_n = 1'b0; pc = 32'h100; pc_plus_4 = 32'h104;
    apply(enc(7'd0, 3'b010, LD), 32'h0, 32'h0, 32'h0);
    check("reset_load_zero", wb_data, 32'h0);
    check("reset_load_rw", {31'd0, reg_write}, 32'd1);
    rst_n = 1'b1;

    apply(enc(7'd0, 3'b000, R), 32'd5, 32'd7, 32'h0);
    check("add", alu_result, 32'd12);
    check("add_rw", {31'd0, reg_write}, 32'd1);
    check("add_wb", wb_data, 32'd12);
    apply(enc(7'b0100000, 3'b000, R), 32'd5, 32'd7, 32'h0);
    check("sub", alu_result, 32'hFFFFFFFE);
    check("sub_zero0", {31'd0, zero}, 32'd0);
    apply(enc(7'b0100000, 3'b000, R), 32'd7, 32'd7, 32'h0);
    check("sub_zero1", {31'd0, zero}, 32'd1);

    apply(enc(7'b0100000, 3'b101, R), 32'h80000000, 32'd4, 32'h0);
    check("sra", alu_result, 32'hF8000000);
    apply(enc(7'd0, 3'b101, R), 32'h80000000, 32'd4, 32'h0);
    check("srl", alu_result, 32'h08000000);
    apply(enc(7'b0100000, 3'b101, I), 32'h80000000, 32'h0, 32'h404);
    check("srai", alu_result, 32'hF8000000);
    apply(enc(7'b0100000, 3'b000, I), 32'd5, 32'h0, 32'h403);
    check("addi_bit30", alu_result, 32'h408);
    apply(enc(7'd0, 3'b010, R), 32'hFFFFFFFF, 32'd1, 32'h0);
    check("slt", alu_result, 32'd1);
    apply(enc(7'd0, 3'b011, R), 32'hFFFFFFFF, 32'd1, 32'h0);
    check("sltu", alu_result, 32'd0);
    apply(enc(7'd0, 3'b001, R), 32'd1, 32'h21, 32'h0);
    check("sll_shamt5", alu_result, 32'd2);
    apply(enc(7'd0, 3'b111, R), 32'hF0F0, 32'h0FF0, 32'h0);
    check("and", alu_result, 32'h00F0);
    apply(enc(7'd0, 3'b110, R), 32'hF0F0, 32'h0FF0, 32'h0);
    check("or", alu_result, 32'hFFF0);
    apply(enc(7'd0, 3'b100, R), 32'hF0F0, 32'h0FF0, 32'h0);
    check("xor", alu_result, 32'hFF00);

    apply(enc(7'd0, 3'b010, ST), 32'h10, 32'hDEADBEEF, 32'd4);
    check("sw_addr", alu_result, 32'h14);
    check("sw_rw", {31'd0, reg_write}, 32'd0);
    apply(enc(7'd0, 3'b010, LD), 32'h10, 32'h0, 32'd4);
    check("lw", wb_data, 32'hDEADBEEF);
    apply(enc(7'd0, 3'b010, LD), 32'h410, 32'h0, 32'd4);
    check("lw_wrap", wb_data, 32'hDEADBEEF);
    apply(enc(7'd0, 3'b010, LD), 32'h11, 32'h0, 32'd4);
    check("lw_lowbits", wb_data, 32'hDEADBEEF);

`ifdef RVX_SUBWORD_EN
    apply(enc(7'd0, 3'b000, LD), 32'h14, 32'h0, 32'd0);
    check("lb", wb_data, 32'hFFFFFFEF);
    apply(enc(7'd0, 3'b100, LD), 32'h15, 32'h0, 32'd0);
    check("lbu", wb_data, 32'h000000BE);
    apply(enc(7'd0, 3'b001, LD), 32'h16, 32'h0, 32'd0);
    check("lh_hi", wb_data, 32'hFFFFDEAD);
    apply(enc(7'd0, 3'b000, ST), 32'h14, 32'h00000012, 32'd0);
    apply(enc(7'd0, 3'b010, LD), 32'h14, 32'h0, 32'd0);
    check("sb_lw", wb_data, 32'hDEADBE12);
`else
    apply(enc(7'd0, 3'b000, LD), 32'h14, 32'h0, 32'd0);
    check("lb_fullword", wb_data, 32'hDEADBEEF);
    apply(enc(7'd0, 3'b000, ST), 32'h14, 32'h00000012, 32'd0);
    apply(enc(7'd0, 3'b010, LD), 32'h14, 32'h0, 32'd0);
    check("sb_fullword", wb_data, 32'h00000012);
`endif

    apply(enc(7'd0, 3'b000, BR), 32'd3, 32'd3, 32'h40);
    check("beq", {30'd0, pc_src}, 32'd1);
    check("br_rw", {31'd0, reg_write}, 32'd0);
    apply(enc(7'd0, 3'b001, BR), 32'd3, 32'd3, 32'h40);
    check("bne", {30'd0, pc_src}, 32'd0);
    apply(enc(7'd0, 3'b110, BR), 32'd1, 32'hFFFFFFFF, 32'h40);
    check("bltu", {30'd0, pc_src}, 32'd1);
    apply(enc(7'd0, 3'b100, BR), 32'd1, 32'hFFFFFFFF, 32'h40);
    check("blt", {30'd0, pc_src}, 32'd0);
    apply(enc(7'd0, 3'b101, BR), 32'd1, 32'hFFFFFFFF, 32'h40);
    check("bge", {30'd0, pc_src}, 32'd1);
    apply(enc(7'd0, 3'b111, BR), 32'd1, 32'hFFFFFFFF, 32'h40);
    check("bgeu", {30'd0, pc_src}, 32'd0);
    apply(enc(7'd0, 3'b010, BR), 32'd3, 32'd3, 32'h40);
    check("br_f3_010", {30'd0, pc_src}, 32'd0);

    apply(enc(7'd0, 3'b000, 7'b1101111), 32'h0, 32'h0, 32'h40);
    check("jal_pcsrc", {30'd0, pc_src}, 32'd1);
    check("jal_wb", wb_data, 32'h104);
    apply(enc(7'd0, 3'b000, 7'b1100111), 32'h200, 32'h0, 32'h8);
    check("jalr_pcsrc", {30'd0, pc_src}, 32'd2);
    check("jalr_rw", {31'd0, reg_write}, 32'd1);
    check("jalr_wb", wb_data, 32'h104);
    apply(enc(7'd0, 3'b000, 7'b0110111), 32'h5, 32'h6, 32'h12345000);
    check("lui", wb_data, 32'h12345000);
    apply(enc(7'd0, 3'b000, 7'b0010111), 32'h5, 32'h6, 32'h1000);
    check("auipc", wb_data, 32'h1100);

    apply(enc(7'd0, 3'b010, ST), 32'd12, 32'h55, 32'd0);
    apply(enc(7'd0, 3'b010, LD), 32'd12, 32'h0, 32'd0);
    check("lw_before_rst", wb_data, 32'h55);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    apply(enc(7'd0, 3'b010, LD), 32'd12, 32'h0, 32'd0);
    check("lw_after_rst", wb_data, 32'h0);

    @(negedge clk);
    rst_n = 1'b0;
    instr = enc(7'd0, 3'b010, ST); rs1_data = 32'd8; rs2_data = 32'hAA; imm = 32'd0;
    #1;
    check("rst_store_addr", alu_result, 32'd8);
    @(posedge clk); #1;
    instr = enc(7'd0, 3'b010, LD);
    #1;
    check("rst_load_zero", wb_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(enc(7'd0, 3'b010, LD), 32'd8, 32'h0, 32'd0);
    check("rst_store_blocked", wb_data, 32'h0);

    apply(32'h0000007F, 32'h20, 32'h77, 32'd0);
    check("illegal_rw", {31'd0, reg_write}, 32'd0);
    check("illegal_pcsrc", {30'd0, pc_src}, 32'd0);
    apply(enc(7'd0, 3'b010, LD), 32'h20, 32'h0, 32'd0);
    check("illegal_no_write", wb_data, 32'h0);
    apply(enc(7'd0, 3'b010, LD), 32'h0, 32'h0, 32'h97);
    check("illegal_no_write2", wb_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
